wb_decode_mux: RTL and testbench

Parametrised single-master, N-slave Wishbone B4 classic/burst decoder-multiplexer for the SweRVolf I/O bus. It is the next-generation replacement for the fixed-width combinational I/O mux:
- Address decode is registered.
- The selected slave is locked for the whole transaction or incrementing burst.
- Unmapped addresses receive a clean error response.
- A per-transaction watchdog terminates hung slaves with an error.
- The last faulting address is captured for the core to read.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_addr_decode.sv | 29 ++
 rtl/wb_decode_mux.sv | 152 +++++++++++++++
 tb/tb_wb_decode_mux.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone decoder/multiplexer.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERR    = 2'd2
  } state_t;

  // Bits needed to index n items; never less than 1 so a single-item
  // range still yields a legal vector.
  function automatic int clog2_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decoder: lowest-index matching slave wins.
module wb_addr_decode
  import wb_pkg::*;
#(
  parameter int                         NUM_SLAVES = 4,
  parameter int                         AW         = 32,
  parameter logic [NUM_SLAVES*AW-1:0]   MATCH_ADDR = {32'h2000, 32'h1100, 32'h1000, 32'h0000},
  parameter logic [NUM_SLAVES*AW-1:0]   MATCH_MASK = {32'hfffff000, 32'hffffffc0, 32'hffffffc0, 32'hfffff000}
) (
  input  logic [AW-1:0]                  adr,
  output logic                           match,
  output logic [clog2_w(NUM_SLAVES)-1:0] idx
);

  localparam int IW = clog2_w(NUM_SLAVES);

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    match = 1'b0;
    idx   = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((adr & MATCH_MASK[i*AW +: AW]) == MATCH_ADDR[i*AW +: AW]) begin
        match = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/wb_decode_mux.sv
// Single-master, N-slave Wishbone decoder/multiplexer with registered decode,
// burst lock, unmapped-address error and per-transaction watchdog.
//
//   state  | meaning
//   IDLE   | no slave selected; waiting for cyc & stb to decode
//   ACTIVE | slave sel_q owns the bus; strobes and responses pass through
//   ERR    | one-cycle error response (unmapped address or timeout)
module wb_decode_mux
  import wb_pkg::*;
#(
  parameter int                         NUM_SLAVES     = 4,
  parameter int                         AW             = 32,
  parameter int                         DW             = 32,
  parameter logic [NUM_SLAVES*AW-1:0]   MATCH_ADDR     = {32'h2000, 32'h1100, 32'h1000, 32'h0000},
  parameter logic [NUM_SLAVES*AW-1:0]   MATCH_MASK     = {32'hfffff000, 32'hffffffc0, 32'hffffffc0, 32'hfffff000},
  parameter int                         TIMEOUT_CYCLES = 255
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_n_i,
  input  logic [AW-1:0]                  wbm_adr_i,
  input  logic [DW-1:0]                  wbm_dat_i,
  input  logic [DW/8-1:0]                wbm_sel_i,
  input  logic                           wbm_we_i,
  input  logic                           wbm_cyc_i,
  input  logic                           wbm_stb_i,
  input  logic [2:0]                     wbm_cti_i,
  input  logic [1:0]                     wbm_bte_i,
  output logic [DW-1:0]                  wbm_dat_o,
  output logic                           wbm_ack_o,
  output logic                           wbm_err_o,
  output logic                           wbm_rty_o,
  output logic [NUM_SLAVES*AW-1:0]       wbs_adr_o,
  output logic [NUM_SLAVES*DW-1:0]       wbs_dat_o,
  output logic [NUM_SLAVES*(DW/8)-1:0]   wbs_sel_o,
  output logic [NUM_SLAVES-1:0]          wbs_we_o,
  output logic [NUM_SLAVES*3-1:0]        wbs_cti_o,
  output logic [NUM_SLAVES*2-1:0]        wbs_bte_o,
  output logic [NUM_SLAVES-1:0]          wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]          wbs_stb_o,
  input  logic [NUM_SLAVES*DW-1:0]       wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]          wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]          wbs_err_i,
  input  logic [NUM_SLAVES-1:0]          wbs_rty_i,
  output logic                           err_irq_o,
  output logic [AW-1:0]                  err_adr_o,
  output logic                           err_to_o
);

  localparam int SW = clog2_w(NUM_SLAVES);
  localparam int CW = clog2_w(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [SW-1:0]   sel_q;
  logic [CW-1:0]   wd_cnt;
  logic            dec_match;
  logic [SW-1:0]   dec_idx;
  logic            s_ack, s_err, s_rty, term, timeout;

  wb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .AW         (AW),
    .MATCH_ADDR (MATCH_ADDR),
    .MATCH_MASK (MATCH_MASK)
  ) u_dec (
    .adr   (wbm_adr_i),
    .match (dec_match),
    .idx   (dec_idx)
  );

  // Request fields go to every slave; only cyc/stb are steered.
  assign wbs_adr_o = {NUM_SLAVES{wbm_adr_i}};
  assign wbs_dat_o = {NUM_SLAVES{wbm_dat_i}};
  assign wbs_sel_o = {NUM_SLAVES{wbm_sel_i}};
  assign wbs_we_o  = {NUM_SLAVES{wbm_we_i}};
  assign wbs_cti_o = {NUM_SLAVES{wbm_cti_i}};
  assign wbs_bte_o = {NUM_SLAVES{wbm_bte_i}};

  assign s_ack   = wbs_ack_i[sel_q];
  assign s_err   = wbs_err_i[sel_q];
  assign s_rty   = wbs_rty_i[sel_q];
  assign term    = (state == ACTIVE) && (s_ack || s_err || s_rty);
  // A termination on the firing cycle wins over the watchdog.
  assign timeout = (TIMEOUT_CYCLES != 0) && (state == ACTIVE) && wbm_cyc_i &&
                   wbm_stb_i && !term && (wd_cnt == TO_LAST);

  assign err_irq_o = (state == ERR);

  // Steer strobes to the locked slave and return its response combinationally.
  always_comb begin
    wbs_cyc_o = '0;
    wbs_stb_o = '0;
    wbm_dat_o = '0;
    wbm_ack_o = 1'b0;
    wbm_err_o = 1'b0;
    wbm_rty_o = 1'b0;
    if (state == ACTIVE) begin
      wbs_cyc_o[sel_q] = wbm_cyc_i;
      wbs_stb_o[sel_q] = wbm_stb_i;
      wbm_dat_o        = wbs_dat_i[int'(sel_q)*DW +: DW];
      wbm_ack_o        = s_ack;
      wbm_err_o        = s_err;
      wbm_rty_o        = s_rty;
    end else if (state == ERR) begin
      wbm_err_o = 1'b1;
    end
  end

  // Decode, burst lock, watchdog and error capture.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state     <= IDLE;
      sel_q     <= '0;
      wd_cnt    <= '0;
      err_adr_o <= '0;
      err_to_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (wbm_cyc_i && wbm_stb_i) begin
            if (dec_match) begin
              state  <= ACTIVE;
              sel_q  <= dec_idx;
              wd_cnt <= '0;
            end else begin
              state     <= ERR;
              err_adr_o <= wbm_adr_i;
              err_to_o  <= 1'b0;
            end
          end
        end
        ACTIVE: begin
          if (term) begin
            wd_cnt <= '0;
            if (!(s_ack && wbm_cyc_i && (wbm_cti_i == CTI_INCR))) state <= IDLE;
          end else if (!wbm_cyc_i) begin
            state <= IDLE;
          end else if (timeout) begin
            state     <= ERR;
            err_adr_o <= wbm_adr_i;
            err_to_o  <= 1'b1;
          end else if (wbm_stb_i && (wd_cnt != '1)) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_decode_mux.sv
// Self-checking bench for wb_decode_mux: directed scenarios plus randomized
// single transfers checked against a map-driven reference of the decode rules.
module tb_wb_decode_mux;

  localparam logic [127:0] MAP_A  = {32'h2000, 32'h1100, 32'h1000, 32'h0000};
  localparam logic [127:0] MASK_A = {32'hfffff000, 32'hffffffc0, 32'hffffffc0, 32'hfffff000};
  // Second instance: slave 0 overlaps slaves 1 and 2.
  localparam logic [127:0] MASK_B = {32'hfffff000, 32'hffffffc0, 32'hfffff000, 32'hffffe000};
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;

  logic [31:0]  a_dat, b_dat;
  logic         a_ack, a_err, a_rty, b_ack, b_err, b_rty;
  logic [127:0] a_sadr, a_sdat, b_sadr, b_sdat;
  logic [15:0]  a_ssel, b_ssel;
  logic [3:0]   a_swe, a_scyc, a_sstb, b_swe, b_scyc, b_sstb;
  logic [11:0]  a_scti, b_scti;
  logic [7:0]   a_sbte, b_sbte;
  logic         a_irq, a_eto, b_irq, b_eto;
  logic [31:0]  a_eadr, b_eadr;

  logic [127:0] s_dat;
  logic [3:0]   s_ack, s_err, s_rty;
  logic [127:0] b_in_dat;
  logic [3:0]   b_in_ack;
  logic [3:0]   b_in_zero;

  assign b_in_dat  = {32'hb3b3_0003, 32'hb2b2_0002, 32'hb1b1_0001, 32'hb0b0_0000};
  assign b_in_ack  = b_sstb;
  assign b_in_zero = 4'b0000;

  int n_assert = 0;
  int n_fail   = 0;

  wb_decode_mux #(.MATCH_ADDR(MAP_A), .MATCH_MASK(MASK_A), .TIMEOUT_CYCLES(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(sel), .wbm_we_i(we),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_cti_i(cti), .wbm_bte_i(bte),
    .wbm_dat_o(a_dat), .wbm_ack_o(a_ack), .wbm_err_o(a_err), .wbm_rty_o(a_rty),
    .wbs_adr_o(a_sadr), .wbs_dat_o(a_sdat), .wbs_sel_o(a_ssel), .wbs_we_o(a_swe),
    .wbs_cti_o(a_scti), .wbs_bte_o(a_sbte), .wbs_cyc_o(a_scyc), .wbs_stb_o(a_sstb),
    .wbs_dat_i(s_dat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .err_irq_o(a_irq), .err_adr_o(a_eadr), .err_to_o(a_eto)
  );

  wb_decode_mux #(.MATCH_ADDR(MAP_A), .MATCH_MASK(MASK_B)) dut_b (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(sel), .wbm_we_i(we),
    .wbm_cyc_i(cyc), .wbm_stb_i(stb), .wbm_cti_i(cti), .wbm_bte_i(bte),
    .wbm_dat_o(b_dat), .wbm_ack_o(b_ack), .wbm_err_o(b_err), .wbm_rty_o(b_rty),
    .wbs_adr_o(b_sadr), .wbs_dat_o(b_sdat), .wbs_sel_o(b_ssel), .wbs_we_o(b_swe),
    .wbs_cti_o(b_scti), .wbs_bte_o(b_sbte), .wbs_cyc_o(b_scyc), .wbs_stb_o(b_sstb),
    .wbs_dat_i(b_in_dat), .wbs_ack_i(b_in_ack), .wbs_err_i(b_in_zero), .wbs_rty_i(b_in_zero),
    .err_irq_o(b_irq), .err_adr_o(b_eadr), .err_to_o(b_eto)
  );

  // Reference decode: first slave in index order whose masked base matches.
  function automatic int ref_slave(input logic [31:0] a, input logic [127:0] base,
                                   input logic [127:0] mask);
    for (int i = 0; i < 4; i++)
      if ((a & mask[i*32 +: 32]) == base[i*32 +: 32]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] oh(input int i);
    logic [3:0] v;
    v = 4'b0000;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_req();
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    s_ack = '0; s_err = '0; s_rty = '0;
  endtask

  // One classic transfer: request at cycle 0, ack after nwait wait cycles.
  task automatic do_xfer(input logic [31:0] a, input logic w, input int nwait);
    int ia, ib;
    logic [31:0] wd, rd;
    ia = ref_slave(a, MAP_A, MASK_A);
    ib = ref_slave(a, MAP_A, MASK_B);
    wd = $urandom;
    rd = $urandom;
    step();
    adr = a; we = w; dat = wd; sel = 4'($urandom); cti = 3'b000; cyc = 1'b1; stb = 1'b1;
    #1;
    chk("cycle0_no_stb", a_sstb, 4'b0000);
    if (ia < 0) begin
      step();
      s_ack = 4'($urandom);
      #1;
      chk("unmapped_err", a_err, 1'b1);
      chk("unmapped_ack", a_ack, 1'b0);
      chk("unmapped_stb", a_sstb, 4'b0000);
      chk("unmapped_irq", a_irq, 1'b1);
      chk("unmapped_eadr", a_eadr, a);
      chk("unmapped_eto", a_eto, 1'b0);
      chk("b_cycle1_stb", b_sstb, oh(ib));
      chk("b_cycle1_err", b_err, ib < 0);
      step();
      drop_req();
      #1;
      chk("unmapped_err_one_cycle", a_err, 1'b0);
      chk("unmapped_irq_one_cycle", a_irq, 1'b0);
    end else begin
      for (int k = 0; k <= nwait; k++) begin
        step();
        s_dat = {$urandom, $urandom, $urandom, $urandom};
        s_dat[ia*32 +: 32] = rd;
        s_ack = 4'($urandom);
        s_ack[ia] = (k == nwait);
        s_err = 4'($urandom) & ~oh(ia);
        s_rty = 4'($urandom) & ~oh(ia);
        #1;
        chk("sel_stb", a_sstb, oh(ia));
        chk("sel_cyc", a_scyc, oh(ia));
        chk("sel_ack", a_ack, k == nwait);
        chk("sel_err", a_err, 1'b0);
        chk("sel_rty", a_rty, 1'b0);
        if (k == nwait) chk("read_data", a_dat, rd);
        if (k == 0) begin
          chk("bcast_we", a_swe, {4{w}});
          chk("bcast_dat", a_sdat[ia*32 +: 32], wd);
          chk("bcast_adr", a_sadr[96 +: 32], a);
          chk("b_cycle1_stb", b_sstb, oh(ib));
          chk("b_cycle1_err", b_err, ib < 0);
        end
      end
      step();
      drop_req();
      #1;
      chk("post_idle_stb", a_sstb, 4'b0000);
      chk("post_ack", a_ack, 1'b0);
      chk("post_err", a_err, 1'b0);
      chk("post_irq", a_irq, 1'b0);
    end
  endtask

  logic [31:0] bases [7];

  initial begin
    bases[0] = 32'h0000; bases[1] = 32'h1000; bases[2] = 32'h1100; bases[3] = 32'h2000;
    bases[4] = 32'h1140; bases[5] = 32'h3000; bases[6] = 32'h1040;
    adr = '0; dat = '0; sel = '0; we = 1'b0; bte = 2'b00;
    drop_req();
    s_dat = '0;

    // Reset state.
    #2;
    chk("rst_stb", a_sstb, 4'b0000);
    chk("rst_cyc", a_scyc, 4'b0000);
    chk("rst_ack", a_ack, 1'b0);
    chk("rst_err", a_err, 1'b0);
    chk("rst_irq", a_irq, 1'b0);
    chk("rst_eadr", a_eadr, 32'h0);
    chk("rst_eto", a_eto, 1'b0);
    step();
    rst_n = 1'b1;

    // Directed single transfers.
    do_xfer(32'h0000_0010, 1'b0, 0);
    do_xfer(32'h0000_1104, 1'b1, 0);
    do_xfer(32'h0000_1140, 1'b0, 0);
    do_xfer(32'h0000_1000, 1'b0, 1);
    do_xfer(32'h0000_1010, 1'b0, TO - 1);

    // Randomized transfers across mapped and unmapped regions.
    for (int t = 0; t < 30; t++)
      do_xfer(bases[$urandom_range(0, 6)] + ($urandom & 32'h3c), 1'($urandom), $urandom_range(0, 3));

    // Four-beat incrementing burst with one wait state per beat.
    step();
    adr = 32'h2000; cti = 3'b010; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    #1;
    chk("burst_cycle0", a_sstb, 4'b0000);
    for (int b = 0; b < 4; b++) begin
      step();
      if (b > 0) begin
        adr = 32'h2000 + 32'(4 * b);
        cti = (b == 3) ? 3'b111 : 3'b010;
      end
      s_ack = 4'b0000;
      #1;
      chk("burst_wait_stb", a_sstb, 4'b1000);
      chk("burst_wait_ack", a_ack, 1'b0);
      step();
      s_ack = 4'b1000;
      s_dat[96 +: 32] = 32'hb000_0000 + 32'(b);
      #1;
      chk("burst_ack_stb", a_sstb, 4'b1000);
      chk("burst_ack", a_ack, 1'b1);
      chk("burst_data", a_dat, 32'hb000_0000 + 32'(b));
    end
    step();
    s_ack = 4'b0000; adr = 32'h2000; cti = 3'b000;
    #1;
    chk("burst_eob_idle", a_sstb, 4'b0000);
    step();
    drop_req();
    step();

    // Slave 1 never answers: watchdog fires.
    step();
    adr = 32'h1000; cti = 3'b000; cyc = 1'b1; stb = 1'b1;
    for (int c = 1; c <= TO; c++) begin
      step();
      #1;
      chk("wd_stall_stb", a_sstb, 4'b0010);
      chk("wd_stall_err", a_err, 1'b0);
    end
    step();
    #1;
    chk("wd_err", a_err, 1'b1);
    chk("wd_cyc_off", a_scyc, 4'b0000);
    chk("wd_irq", a_irq, 1'b1);
    chk("wd_eto", a_eto, 1'b1);
    chk("wd_eadr", a_eadr, 32'h1000);
    step();
    drop_req();
    #1;
    chk("wd_err_one_cycle", a_err, 1'b0);
    chk("wd_eto_held", a_eto, 1'b1);

    // Master abandons a stalled access.
    step();
    adr = 32'h0000_0010; cyc = 1'b1; stb = 1'b1;
    step();
    #1;
    chk("abort_stb", a_sstb, 4'b0001);
    step();
    step();
    drop_req();
    #1;
    chk("abort_cyc_same_cycle", a_scyc, 4'b0000);
    chk("abort_no_err", a_err, 1'b0);
    step();
    #1;
    chk("abort_idle_err", a_err, 1'b0);
    chk("abort_idle_irq", a_irq, 1'b0);
    do_xfer(32'h0000_0020, 1'b0, 0);

    // Reset asserted mid-transfer.
    step();
    adr = 32'h0000_0000; cyc = 1'b1; stb = 1'b1;
    step();
    #1;
    chk("rstmid_cyc_before", a_scyc, 4'b0001);
    step();
    s_ack = 4'b0001;
    rst_n = 1'b0;
    #1;
    chk("rstmid_cyc", a_scyc, 4'b0000);
    chk("rstmid_stb", a_sstb, 4'b0000);
    chk("rstmid_ack", a_ack, 1'b0);
    chk("rstmid_err", a_err, 1'b0);
    chk("rstmid_eadr", a_eadr, 32'h0);
    chk("rstmid_eto", a_eto, 1'b0);
    drop_req();
    step();
    rst_n = 1'b1;
    #1;
    chk("rstmid_release_stb", a_sstb, 4'b0000);
    do_xfer(32'h0000_2008, 1'b1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
